// File: rtl/blink_pkg.sv
// Shared definitions for the LED brightness path: level width, slot range, FSM states.
// The duty-step rule lives here so the upstream counter and the PWM agree on range limits.
package blink_pkg;

  localparam int unsigned LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] MAX_SLOT = 4'd14;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Slewed steps cannot wrap: an increment only happens when level > duty, so duty < 15.
  function automatic logic [LEVEL_W-1:0] next_duty(
    input logic [LEVEL_W-1:0] duty,
    input logic [LEVEL_W-1:0] level,
    input bit                 slew
  );
    logic [LEVEL_W-1:0] res;
    res = duty;
    if (!slew) begin
      res = level;
    end else if (level > duty) begin
      res = duty + 1'b1;
    end else if (level < duty) begin
      res = duty - 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 and flags the last count; clear holds it at 0.
// tick_o is combinational from the count register, so it is valid in the same cycle.
module tick_gen #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  output logic tick_o
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("tick_gen: PRESCALE must be within 1..256");
  end

  logic [CNT_W-1:0] r_cnt;

  assign tick_o = (r_cnt == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear || tick_o) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/level_pwm.sv
// LED PWM: 15 slots of PRESCALE cycles; duty reloaded from level_i only at period boundaries.
// pwm_o follows registered slot/duty combinationally; period_o pulses the cycle after a boundary.
module level_pwm
  import blink_pkg::*;
#(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned SLEW     = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [LEVEL_W-1:0] level_i,
  output logic               pwm_o,
  output logic [LEVEL_W-1:0] duty_o,
  output logic               period_o,
  output logic               busy_o
);

  state_t             r_state;
  logic [LEVEL_W-1:0] r_slot;
  logic [LEVEL_W-1:0] r_duty;
  logic               r_period;

  logic               w_tick;
  logic               w_clear;
  logic               w_boundary;
  logic [LEVEL_W-1:0] w_duty_next;

  // Holding the prescaler clear while idle makes the first RUN slot a full PRESCALE long.
  assign w_clear     = (r_state == IDLE);
  assign w_boundary  = (r_state == RUN) && w_tick && (r_slot == MAX_SLOT);
  assign w_duty_next = next_duty(r_duty, level_i, SLEW != 0);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (w_clear),
    .tick_o (w_tick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_slot   <= '0;
      r_duty   <= '0;
      r_period <= 1'b0;
    end else begin
      r_period <= w_boundary;
      case (r_state)
        IDLE: begin
          r_slot <= '0;
          if (en_i) begin
            r_state <= RUN;
            r_duty  <= w_duty_next;
          end
        end
        RUN: begin
          if (w_tick) begin
            if (r_slot == MAX_SLOT) begin
              r_slot <= '0;
              if (en_i) begin
                r_duty <= w_duty_next;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_slot <= r_slot + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign pwm_o    = (r_state == RUN) && (r_slot < r_duty);
  assign duty_o   = r_duty;
  assign period_o = r_period;
  assign busy_o   = (r_state == RUN);

endmodule

// File: tb/tb_level_pwm.sv
// Bench for level_pwm: dut 0 is PRESCALE=4/SLEW=0, dut 1 is PRESCALE=1/SLEW=1.
// A cycle-position model (period index arithmetic) is compared every cycle.
module tb_level_pwm;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_a     [2];
  logic [3:0] lvl_a    [2];
  logic       pwm_a    [2];
  logic [3:0] duty_a   [2];
  logic       period_a [2];
  logic       busy_a   [2];

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state per dut
  int m_p    [2] = '{4, 1};
  int m_slew [2] = '{0, 1};
  int m_run  [2];
  int m_c    [2];
  int m_duty [2];
  int m_per  [2];

  always #5 clk_i = ~clk_i;

  level_pwm #(.PRESCALE(4), .SLEW(0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_a[0]), .level_i(lvl_a[0]),
    .pwm_o(pwm_a[0]), .duty_o(duty_a[0]), .period_o(period_a[0]), .busy_o(busy_a[0])
  );

  level_pwm #(.PRESCALE(1), .SLEW(1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_a[1]), .level_i(lvl_a[1]),
    .pwm_o(pwm_a[1]), .duty_o(duty_a[1]), .period_o(period_a[1]), .busy_o(busy_a[1])
  );

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_c[i] = 0; m_duty[i] = 0; m_per[i] = 0;
    end
  endtask

  function automatic int new_duty(input int i);
    int lv;
    lv = int'(lvl_a[i]);
    if (m_slew[i] == 0) return lv;
    if (lv > m_duty[i]) return m_duty[i] + 1;
    if (lv < m_duty[i]) return m_duty[i] - 1;
    return m_duty[i];
  endfunction

  task automatic model_step(input int i);
    m_per[i] = 0;
    if (m_run[i] == 0) begin
      if (en_a[i]) begin
        m_run[i] = 1; m_c[i] = 0; m_duty[i] = new_duty(i);
      end
    end else if (m_c[i] == 15 * m_p[i] - 1) begin
      m_per[i] = 1; m_c[i] = 0;
      if (en_a[i]) m_duty[i] = new_duty(i);
      else         m_run[i] = 0;
    end else begin
      m_c[i]++;
    end
  endtask

  task automatic check_model();
    logic [6:0] got, exp;
    logic       e_pwm;
    for (int i = 0; i < 2; i++) begin
      e_pwm = (m_run[i] != 0) && ((m_c[i] / m_p[i]) < m_duty[i]);
      exp = {e_pwm, 4'(m_duty[i]), m_per[i] != 0, m_run[i] != 0};
      got = {pwm_a[i], duty_a[i], period_a[i], busy_a[i]};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL model_dut%0d @%0t: got {pwm,duty,per,busy}=%b, expected %b", i, $time, got, exp);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    if (rst_ni) for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk_i);
    check_model();
  endtask

  task automatic run_win(input int n, output int hi, output int per);
    hi = 0; per = 0;
    for (int k = 0; k < n; k++) begin
      cycle();
      hi  += int'(pwm_a[0]);
      per += int'(period_a[0]);
    end
  endtask

  // Called at a negedge: reset low across one rising edge, then released.
  task automatic reset_pulse();
    rst_ni = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_async_dut%0d", i),
          int'({pwm_a[i], duty_a[i], period_a[i], busy_a[i]}), 0);
    @(posedge clk_i);
    @(negedge clk_i);
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_held_dut%0d", i),
          int'({pwm_a[i], duty_a[i], period_a[i], busy_a[i]}), 0);
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic [3:0] lvl;
    int         hi;
    int         per;
    int         duty;
    int         busy;
  } vec_t;

  vec_t tbl [8];
  int   exp_up   [4] = '{1, 2, 3, 3};
  int   exp_down [4] = '{2, 1, 0, 0};

  initial begin
    int hi, per, tot;

    // each row spans exactly one 60-cycle period window of dut 0
    tbl[0] = '{1'b1, 4'd5,  20, 0, 5,  1};
    tbl[1] = '{1'b1, 4'd15, 60, 1, 15, 1};
    tbl[2] = '{1'b1, 4'd0,  0,  1, 0,  1};
    tbl[3] = '{1'b1, 4'd5,  20, 1, 5,  1};
    tbl[4] = '{1'b0, 4'd9,  0,  1, 5,  0};
    tbl[5] = '{1'b0, 4'd3,  0,  0, 5,  0};
    tbl[6] = '{1'b1, 4'd10, 40, 0, 10, 1};
    tbl[7] = '{1'b1, 4'd10, 40, 1, 10, 1};

    rst_ni = 1'b0;
    for (int i = 0; i < 2; i++) begin en_a[i] = 1'b0; lvl_a[i] = 4'd0; end
    model_reset();

    @(negedge clk_i);
    for (int i = 0; i < 2; i++)
      chk($sformatf("por_dut%0d", i), int'({pwm_a[i], duty_a[i], period_a[i], busy_a[i]}), 0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle();

    for (int v = 0; v < 8; v++) begin
      en_a[0] = tbl[v].en; lvl_a[0] = tbl[v].lvl;
      run_win(60, hi, per);
      chk($sformatf("tbl%0d_high", v), hi, tbl[v].hi);
      chk($sformatf("tbl%0d_period", v), per, tbl[v].per);
      chk($sformatf("tbl%0d_duty", v), int'(duty_a[0]), tbl[v].duty);
      chk($sformatf("tbl%0d_busy", v), int'(busy_a[0]), tbl[v].busy);
    end

    // level change mid-period must not disturb the running period
    lvl_a[0] = 4'd5;
    run_win(30, hi, per);
    tot = hi;
    lvl_a[0] = 4'd12;
    run_win(30, hi, per);
    tot += hi;
    chk("midchange_high", tot, 20);
    chk("midchange_duty", int'(duty_a[0]), 5);
    run_win(60, hi, per);
    chk("after_change_high", hi, 48);
    chk("after_change_duty", int'(duty_a[0]), 12);

    // enable dropped at cycle 10: period completes, then idle
    run_win(10, hi, per);
    tot = hi;
    en_a[0] = 1'b0;
    run_win(50, hi, per);
    tot += hi;
    chk("en_drop_high", tot, 48);
    chk("en_drop_busy_c59", int'(busy_a[0]), 1);
    run_win(1, hi, per);
    chk("en_drop_idle", int'({pwm_a[0], duty_a[0], period_a[0], busy_a[0]}), 7'b0_1100_1_0);

    // reset at cycle 25, then a full fresh period
    en_a[0] = 1'b1; lvl_a[0] = 4'd7;
    run_win(25, hi, per);
    chk("pre_reset_high", hi, 25);
    reset_pulse();
    run_win(60, hi, per);
    chk("post_reset_high", hi, 28);
    chk("post_reset_period", per, 0);
    run_win(1, hi, per);
    chk("post_reset_boundary", per, 1);

    // slewed duty on dut 1 (15-cycle periods)
    en_a[1] = 1'b1; lvl_a[1] = 4'd3;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 15; k++) cycle();
      chk($sformatf("slew_up%0d", p), int'(duty_a[1]), exp_up[p]);
    end
    lvl_a[1] = 4'd0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 15; k++) cycle();
      chk($sformatf("slew_down%0d", p), int'(duty_a[1]), exp_down[p]);
    end

    // randomized traffic, checked cycle by cycle against the model
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 19) == 0) en_a[i] = ($urandom_range(0, 9) < 8);
        if ($urandom_range(0, 7) == 0)  lvl_a[i] = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 999) == 0) reset_pulse();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
